// File: rtl/vector_mem_sequencer.sv
// Vector load/store sequencer between the execute stage and the single-port
// data RAM. A load gathers LANES consecutive RAM words into one vector; a store
// scatters one vector into LANES consecutive RAM words. The scalar pipeline is
// held off through stall while an operation is in flight.
module vector_mem_sequencer #(
   parameter int DATA_W = 16,
   parameter int LANES  = 8,
   parameter int ADDR_W = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      is_store,
   input  logic [ADDR_W-1:0]         base_addr,
   input  logic [DATA_W*LANES-1:0]   store_vector,
   output logic                      busy,
   output logic                      stall,
   output logic                      done,
   output logic [DATA_W*LANES-1:0]   load_vector,
   output logic [ADDR_W-1:0]         ram_address,
   output logic [DATA_W-1:0]         ram_data,
   output logic                      ram_wren,
   input  logic [DATA_W-1:0]         ram_q
);

   localparam int VEC_W = DATA_W * LANES;
   localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      DRAIN,
      STORE,
      DONE
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  lane;
   logic [VEC_W-1:0]  store_shift;
   logic [CNT_W-1:0]  capture_lane;

   // RAM read data lags its address by one cycle, so the lane being captured is
   // one behind the lane being addressed; in DRAIN it is the final lane.
   assign capture_lane = (state == DRAIN) ? LAST_LANE : lane - CNT_W'(1);

   // The pipeline must freeze in the very cycle a request is accepted, before busy rises.
   assign stall = busy | (start & (state == IDLE));

   // Sequencer FSM: walks the lane counter, drives the RAM port and assembles load data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         lane        <= '0;
         store_shift <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         load_vector <= '0;
         ram_address <= '0;
         ram_data    <= '0;
         ram_wren    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  lane        <= '0;
                  busy        <= 1'b1;
                  ram_address <= base_addr;
                  if (is_store) begin
                     state       <= STORE;
                     store_shift <= store_vector;
                     ram_data    <= store_vector[DATA_W-1:0];
                     ram_wren    <= 1'b1;
                  end else begin
                     state <= LOAD;
                  end
               end
            end

            LOAD: begin
               if (lane != '0) begin
                  load_vector[int'(capture_lane)*DATA_W +: DATA_W] <= ram_q;
               end
               if (lane == LAST_LANE) begin
                  state       <= DRAIN;
                  ram_address <= '0;
               end else begin
                  lane        <= lane + CNT_W'(1);
                  ram_address <= ram_address + ADDR_W'(1);
               end
            end

            DRAIN: begin
               load_vector[int'(capture_lane)*DATA_W +: DATA_W] <= ram_q;
               lane  <= '0;
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= DONE;
            end

            STORE: begin
               if (lane == LAST_LANE) begin
                  lane        <= '0;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  ram_wren    <= 1'b0;
                  ram_address <= '0;
                  ram_data    <= '0;
                  state       <= DONE;
               end else begin
                  lane        <= lane + CNT_W'(1);
                  ram_address <= ram_address + ADDR_W'(1);
                  ram_data    <= store_shift[2*DATA_W-1:DATA_W];
                  store_shift <= store_shift >> DATA_W;
               end
            end

            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               state    <= IDLE;
               busy     <= 1'b0;
               done     <= 1'b0;
               ram_wren <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Self-checking bench for vector_mem_sequencer: a RAM model, a transaction-level
// reference model, a per-cycle compare process, directed scenarios and a random run.
module tb_vector_mem_sequencer;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          is_store = 1'b0;
   logic [15:0]   base_addr = 16'h0;
   logic [127:0]  store_vector = 128'h0;
   logic          busy;
   logic          stall;
   logic          done;
   logic [127:0]  load_vector;
   logic [15:0]   ram_address;
   logic [15:0]   ram_data;
   logic          ram_wren;
   logic [15:0]   ram_q;

   int checks = 0;
   int passed = 0;
   int done_seen = 0;
   int stall_seen = 0;

   logic [15:0]   ram     [0:65535];
   logic [15:0]   ref_mem [0:65535];
   logic [15:0]   addr_trace [0:7];

   // Reference model state: one transaction in flight, counted in cycles since acceptance.
   bit            m_active;
   int            m_k;
   bit            m_store;
   logic [15:0]   m_base;
   logic [127:0]  m_vec;
   logic [127:0]  m_lv;

   vector_mem_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .is_store     (is_store),
      .base_addr    (base_addr),
      .store_vector (store_vector),
      .busy         (busy),
      .stall        (stall),
      .done         (done),
      .load_vector  (load_vector),
      .ram_address  (ram_address),
      .ram_data     (ram_data),
      .ram_wren     (ram_wren),
      .ram_q        (ram_q)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Initial RAM image shared by the RAM and the model: the 0x20 window holds 0x1000+i.
   function automatic logic [15:0] initWord(input int a);
      if (a >= 'h20 && a < 'h28) return 16'(32'h1000 + a - 'h20);
      return 16'((a * 40503) ^ 'h3C5A);
   endfunction

   // Gather one vector from the model's memory, lane i from base+i with 16-bit wrap.
   function automatic logic [127:0] gather(input logic [15:0] b);
      logic [127:0] v;
      logic [15:0]  idx;
      v = '0;
      for (int i = 0; i < 8; i++) begin
         idx = b + 16'(i);
         v[i*16 +: 16] = ref_mem[idx];
      end
      return v;
   endfunction

   // Single comparison: counts every check and reports any disagreement.
   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Synchronous single-port RAM: write on wren, read data one cycle after the address.
   initial begin
      for (int a = 0; a < 65536; a++) ram[a] = initWord(a);
      ram_q = 16'h0;
      forever begin
         @(posedge clk);
         if (ram_wren) ram[ram_address] <= ram_data;
         ram_q <= ram[ram_address];
      end
   end

   // Reference model: accepts start only when no transaction is in flight, retires a
   // load after ten cycles (0..9) and a store after nine (0..8), and applies effects to its memory.
   initial begin
      for (int a = 0; a < 65536; a++) ref_mem[a] = initWord(a);
      m_active = 1'b0;
      m_k      = 0;
      m_store  = 1'b0;
      m_base   = 16'h0;
      m_vec    = '0;
      m_lv     = '0;
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) begin
            m_active <= 1'b0;
            m_k      <= 0;
            m_lv     <= '0;
         end else if (m_active) begin
            if (m_store && m_k < 8) ref_mem[m_base + 16'(m_k)] <= m_vec[m_k*16 +: 16];
            if (!m_store && m_k == 8) m_lv <= gather(m_base);
            if ((m_store && m_k == 8) || (!m_store && m_k == 9)) m_active <= 1'b0;
            else m_k <= m_k + 1;
         end else if (start) begin
            m_active <= 1'b1;
            m_k      <= 0;
            m_store  <= is_store;
            m_base   <= base_addr;
            m_vec    <= store_vector;
         end
      end
   end

   // Event counters used by the directed scenarios to count done pulses and stall cycles.
   always @(negedge clk) begin
      if (reset) begin
         if (done)  done_seen  <= done_seen + 1;
         if (stall) stall_seen <= stall_seen + 1;
      end
   end

   // Per-cycle compare of every DUT output against what the model says the cycle must show.
   always @(negedge clk) begin : cmp
      logic        eb, ed, ew, ca, cd, cl;
      logic [15:0] ea, edat;
      if (reset) begin
         eb = 1'b0; ed = 1'b0; ew = 1'b0; ea = 16'h0; edat = 16'h0;
         ca = 1'b1; cd = 1'b1; cl = 1'b1;
         if (m_active) begin
            if (m_store) begin
               if (m_k < 8) begin
                  eb = 1'b1; ew = 1'b1;
                  ea = m_base + 16'(m_k);
                  edat = m_vec[m_k*16 +: 16];
               end else begin
                  ed = 1'b1; ca = 1'b0; cd = 1'b0;
               end
            end else begin
               cd = 1'b0;
               if (m_k < 8) begin
                  eb = 1'b1;
                  ea = m_base + 16'(m_k);
                  cl = (m_k == 0);
               end else if (m_k == 8) begin
                  eb = 1'b1; cl = 1'b0;
               end else begin
                  ed = 1'b1; ca = 1'b0;
               end
            end
         end
         checkOutput("busy", 128'(busy), 128'(eb));
         checkOutput("done", 128'(done), 128'(ed));
         checkOutput("ram_wren", 128'(ram_wren), 128'(ew));
         checkOutput("stall", 128'(stall), 128'(eb | (start & !m_active)));
         if (ca) checkOutput("ram_address", 128'(ram_address), 128'(ea));
         if (cd) checkOutput("ram_data", 128'(ram_data), 128'(edat));
         if (cl) checkOutput("load_vector", load_vector, m_lv);
      end
   end

   // Advance to just after the next rising edge, where inputs are changed.
   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for done, counting negedges from the current cycle and tracing addresses.
   task automatic waitDone(output int lat);
      int c;
      bit found;
      c = 0;
      found = 1'b0;
      while (!found && c < 30) begin
         @(negedge clk);
         if (c < 8) addr_trace[c] = ram_address;
         if (done) found = 1'b1;
         else c++;
      end
      checkOutput("done_arrives", 128'(found), 128'(1));
      lat = c;
   endtask

   // Issue one operation from IDLE, scramble the inputs after acceptance, wait for done.
   task automatic applyStimulus(input bit st, input logic [15:0] b, input logic [127:0] v, output int lat);
      is_store = st;
      base_addr = b;
      store_vector = v;
      start = 1'b1;
      nextCycle();
      start = 1'b0;
      is_store = 1'($urandom_range(0, 1));
      base_addr = 16'($urandom);
      store_vector = {$urandom, $urandom, $urandom, $urandom};
      waitDone(lat);
      nextCycle();
   endtask

   // Directed scenarios followed by a randomized run.
   initial begin : stim
      int lat, d0, s0;
      logic [127:0] v1, v2;
      logic [15:0] last_store_base;
      logic [15:0] wrap_exp [0:7];
      wrap_exp = '{16'hFFFD, 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004};
      last_store_base = 16'h0040;

      #2;
      checkOutput("rst_busy", 128'(busy), 128'(0));
      checkOutput("rst_stall", 128'(stall), 128'(0));
      checkOutput("rst_done", 128'(done), 128'(0));
      checkOutput("rst_wren", 128'(ram_wren), 128'(0));
      checkOutput("rst_addr", 128'(ram_address), 128'(0));
      checkOutput("rst_data", 128'(ram_data), 128'(0));
      checkOutput("rst_load_vector", load_vector, 128'(0));
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      nextCycle();

      $display("[TB] load from 0x0020");
      applyStimulus(1'b0, 16'h0020, 128'h0, lat);
      checkOutput("load_latency", 128'(lat), 128'(9));
      checkOutput("load_0020_vector", load_vector, 128'h1007_1006_1005_1004_1003_1002_1001_1000);

      $display("[TB] store to 0x0040 and read back");
      applyStimulus(1'b1, 16'h0040, 128'hA0A7_A0A6_A0A5_A0A4_A0A3_A0A2_A0A1_A0A0, lat);
      checkOutput("store_latency", 128'(lat), 128'(8));
      for (int i = 0; i < 8; i++)
         checkOutput($sformatf("store_ram_%0d", i), 128'(ram[16'h40 + 16'(i)]), 128'(16'hA0A0 + 16'(i)));
      applyStimulus(1'b0, 16'h0040, 128'h0, lat);
      checkOutput("load_0040_vector", load_vector, 128'hA0A7_A0A6_A0A5_A0A4_A0A3_A0A2_A0A1_A0A0);

      $display("[TB] wrapping load from 0xFFFD");
      applyStimulus(1'b0, 16'hFFFD, 128'h0, lat);
      for (int i = 0; i < 8; i++)
         checkOutput($sformatf("wrap_addr_%0d", i), 128'(addr_trace[i]), 128'(wrap_exp[i]));

      $display("[TB] start pulses during a load");
      d0 = done_seen;
      s0 = stall_seen;
      is_store = 1'b0;
      base_addr = 16'h0020;
      start = 1'b1;
      nextCycle();
      start = 1'b0;
      repeat (3) nextCycle();
      start = 1'b1;
      nextCycle();
      start = 1'b0;
      repeat (5) nextCycle();
      start = 1'b1;
      nextCycle();
      start = 1'b0;
      nextCycle();
      checkOutput("pulse_done_count", 128'(done_seen - d0), 128'(1));
      checkOutput("pulse_stall_cycles", 128'(stall_seen - s0), 128'(10));

      $display("[TB] reset during load cycle 4");
      is_store = 1'b0;
      base_addr = 16'h0100;
      start = 1'b1;
      nextCycle();
      start = 1'b0;
      repeat (4) nextCycle();
      d0 = done_seen;
      reset = 1'b0;
      #1;
      checkOutput("abort_busy", 128'(busy), 128'(0));
      checkOutput("abort_stall", 128'(stall), 128'(0));
      checkOutput("abort_wren", 128'(ram_wren), 128'(0));
      checkOutput("abort_load_vector", load_vector, 128'(0));
      repeat (2) nextCycle();
      reset = 1'b1;
      repeat (3) nextCycle();
      checkOutput("abort_no_done", 128'(done_seen - d0), 128'(0));
      applyStimulus(1'b0, 16'h0020, 128'h0, lat);
      checkOutput("after_abort_latency", 128'(lat), 128'(9));
      checkOutput("after_abort_vector", load_vector, 128'h1007_1006_1005_1004_1003_1002_1001_1000);

      $display("[TB] held start, alternating store/load");
      v1 = {$urandom, $urandom, $urandom, $urandom};
      v2 = {$urandom, $urandom, $urandom, $urandom};
      is_store = 1'b1;
      base_addr = 16'h0300;
      store_vector = v1;
      start = 1'b1;
      nextCycle();
      waitDone(lat);
      checkOutput("held_store_latency", 128'(lat), 128'(8));
      is_store = 1'b0;
      waitDone(lat);
      checkOutput("held_load_gap", 128'(lat), 128'(10));
      checkOutput("held_load_vector", load_vector, v1);
      is_store = 1'b1;
      base_addr = 16'h0380;
      store_vector = v2;
      waitDone(lat);
      checkOutput("held_store_gap", 128'(lat), 128'(9));
      start = 1'b0;
      nextCycle();
      applyStimulus(1'b0, 16'h0380, 128'h0, lat);
      checkOutput("held_readback_vector", load_vector, v2);

      $display("[TB] randomized operations");
      for (int n = 0; n < 40; n++) begin
         bit st;
         logic [15:0] b;
         int sel;
         st = 1'($urandom_range(0, 1));
         sel = $urandom_range(0, 3);
         if (sel == 0) b = last_store_base;
         else if (sel == 1) b = 16'hFFF8 + 16'($urandom_range(0, 7));
         else b = 16'($urandom);
         applyStimulus(st, b, {$urandom, $urandom, $urandom, $urandom}, lat);
         checkOutput("rand_latency", 128'(lat), st ? 128'(8) : 128'(9));
         if (st) last_store_base = b;
         repeat ($urandom_range(0, 3)) nextCycle();
      end

      repeat (2) nextCycle();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
